// File: rtl/br_wb_sequencer_if.sv
// -----------------------------------------------------------------------------
// br_wb_sequencer_if
// Groups the writeback request handshake and the register-bank write port
// driven by br_wb_sequencer.
//
// Signals:
//   req_valid  producer -> sequencer   request valid
//   req_ready  sequencer -> producer   sequencer can accept a request
//   req_addr   producer -> sequencer   destination register (AW bits)
//   req_data   producer -> sequencer   data to write (DW bits)
//   br_a3      sequencer -> BR         write address
//   br_wd      sequencer -> BR         write data
//   br_we      sequencer -> BR         write enable
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready never depends on req_valid. A producer holds
// req_addr/req_data stable while req_valid=1 and req_ready=0.
//
// Modports:
//   master  the EX/MEM side (drives requests, observes the BR write port)
//   slave   the sequencer
// -----------------------------------------------------------------------------
interface br_wb_sequencer_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [AW-1:0] br_a3;
    logic [DW-1:0] br_wd;
    logic          br_we;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, br_a3, br_wd, br_we
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, br_a3, br_wd, br_we
    );
endinterface

// File: rtl/br_wb_sequencer.sv
// -----------------------------------------------------------------------------
// br_wb_sequencer
// Write-side initiator for the 32x32 register bank. Writeback requests are
// queued in a DEPTH-entry FIFO and issued to the BR write port (a3/wd/we) at
// most once per cycle through a registered output stage.
//
// Optional feature macro: WB_FORWARD_EN
//   defined   : fwd_hit*/fwd_data* report the youngest pending write for
//               rd_a1_i/rd_a2_i (FIFO entries and the output register).
//   undefined : fwd_hit*/fwd_data* are tied to 0 and no compare logic exists.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   bus          br_wb_sequencer_if.slave: req_valid/ready/addr/data, br_a3/wd/we
//   flush_i      discard all queued (not yet issued) requests
//   br_hold_i    pause issuing to BR
//   rd_a1_i      BR read address 1 (forwarding lookup)
//   rd_a2_i      BR read address 2 (forwarding lookup)
//   fwd_hit1_o   rd_a1_i matches a pending write
//   fwd_data1_o  youngest pending data for rd_a1_i
//   fwd_hit2_o   rd_a2_i matches a pending write
//   fwd_data2_o  youngest pending data for rd_a2_i
//   count_o      FIFO occupancy (output register not included)
//   busy_o       count_o != 0 or br_we == 1
//   state_o      FSM state (0=IDLE, 1=DRAIN, 2=HOLD)
// -----------------------------------------------------------------------------
module br_wb_sequencer #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 5,
    parameter  int DW    = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    br_wb_sequencer_if.slave    bus,
    input  logic                flush_i,
    input  logic                br_hold_i,
    input  logic [AW-1:0]       rd_a1_i,
    input  logic [AW-1:0]       rd_a2_i,
    output logic                fwd_hit1_o,
    output logic [DW-1:0]       fwd_data1_o,
    output logic                fwd_hit2_o,
    output logic [DW-1:0]       fwd_data2_o,
    output logic [CW-1:0]       count_o,
    output logic                busy_o,
    output logic [1:0]          state_o
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] br_a3_q, br_a3_d;
    logic [DW-1:0] br_wd_q, br_wd_d;
    logic          br_we_q, br_we_d;

    logic [AW-1:0] mem_addr_q [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];

    logic req_ready;
    logic push;
    logic pop;

    // Ready looks only at registered occupancy and flush, never at req_valid.
    assign req_ready = (count_q < CW'(DEPTH)) && !flush_i;

    // Writes to x0 complete the handshake but are dropped here.
    assign push = bus.req_valid && req_ready && (bus.req_addr != '0);
    assign pop  = (count_q != '0) && !br_hold_i && !flush_i;

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and output register next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        br_a3_d  = br_a3_q;
        br_wd_d  = br_wd_q;
        br_we_d  = 1'b0;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                br_a3_d  = mem_addr_q[rd_ptr_q];
                br_wd_d  = mem_data_q[rd_ptr_q];
                br_we_d  = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM next state; issue decisions above come from count/hold/flush,
    // and the state tracks them for observability.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush_i || (count_d == '0)) begin
                    state_d = ST_IDLE;
                end else if (br_hold_i) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush_i || (count_d == '0)) begin
                    state_d = ST_IDLE;
                end else if (!br_hold_i) begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            br_a3_q  <= '0;
            br_wd_q  <= '0;
            br_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            br_a3_q  <= br_a3_d;
            br_wd_q  <= br_wd_d;
            br_we_q  <= br_we_d;
        end
    end

    // Storage needs no reset: an entry is only read while count says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= bus.req_addr;
            mem_data_q[wr_ptr_q] <= bus.req_data;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.br_a3     = br_a3_q;
    assign bus.br_wd     = br_wd_q;
    assign bus.br_we     = br_we_q;
    assign count_o       = count_q;
    assign busy_o        = (count_q != '0) || br_we_q;
    assign state_o       = state_q;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
`ifdef WB_FORWARD_EN
    // Walk from oldest to youngest so the last match wins: output register
    // first, then FIFO entries from head to tail. Result is {hit, data}.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] a);
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if (br_we_q && (br_a3_q == a)) begin
            hit  = 1'b1;
            data = br_wd_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (mem_addr_q[idx] == a)) begin
                hit  = 1'b1;
                data = mem_data_q[idx];
            end
        end
        // x0 is never forwarded.
        if (a == '0) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    always_comb begin
        {fwd_hit1_o, fwd_data1_o} = fwd_lookup(rd_a1_i);
        {fwd_hit2_o, fwd_data2_o} = fwd_lookup(rd_a2_i);
    end
`else
    assign fwd_hit1_o  = 1'b0;
    assign fwd_data1_o = '0;
    assign fwd_hit2_o  = 1'b0;
    assign fwd_data2_o = '0;

    // Read addresses have no consumer when forwarding is compiled out.
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_a1_i, rd_a2_i};
`endif

endmodule
